// File: rtl/pulse_interval_gen.sv
// Purpose : programmable interval pulse generator; a prescaler makes a 1 s tick,
//           a seconds counter fires pulse_out every N ticks (N loadable, reset 5).
// Latency : all outputs are registered; tick/pulse assert in the cycle after the
//           prescaler wrap edge. There is no backpressure; strobes are fire-and-forget.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         level: 1 = run, 0 = idle with counters cleared
//   interval_load  one-cycle strobe sampling interval_secs (0 is treated as 1)
//   interval_secs  requested interval in seconds
//   pulse_out      one-cycle strobe at the end of each interval
//   tick_1s        one-cycle strobe on every prescaler wrap
//   sec_count      seconds elapsed in the current interval
//   running        high while the FSM is in RUN
//
// Build option: PULSE_GEN_FAST_SIM_EN forces the prescaler divisor to 4 so
// simulations see a tick every 4 cycles; otherwise the divisor is DIV.

module pulse_interval_gen #(
  parameter int DIV          = 100_000_000,
  parameter int SEC_W        = 8,
  parameter int DEFAULT_SECS = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             interval_load,
  input  logic [SEC_W-1:0] interval_secs,
  output logic             pulse_out,
  output logic             tick_1s,
  output logic [SEC_W-1:0] sec_count,
  output logic             running
);

`ifdef PULSE_GEN_FAST_SIM_EN
  localparam int EFF_DIV = 4;
`else
  localparam int EFF_DIV = DIV;
`endif

  localparam int PRE_W = (EFF_DIV > 1) ? $clog2(EFF_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(EFF_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO  = '0;
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);
  localparam logic [SEC_W-1:0] SEC_ZERO  = '0;
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [SEC_W-1:0] SEC_RESET = SEC_W'(DEFAULT_SECS);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic             state;
  logic [PRE_W-1:0] prescale;
  logic [SEC_W-1:0] active_interval;
  logic [SEC_W-1:0] pending_interval;
  logic             pending_vld;

  logic [SEC_W-1:0] load_val;
  logic             pre_wrap;
  logic             sec_last;

  // A zero interval would never terminate; treat it as one second.
  assign load_val = (interval_secs == SEC_ZERO) ? SEC_ONE : interval_secs;
  assign pre_wrap = (prescale == PRE_MAX);
  // active_interval only changes while sec_count is 0, so >= is equivalent
  // to == in normal operation and keeps the counter bounded regardless.
  assign sec_last = (sec_count >= (active_interval - SEC_ONE));

  assign running = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      prescale         <= PRE_ZERO;
      sec_count        <= SEC_ZERO;
      pulse_out        <= 1'b0;
      tick_1s          <= 1'b0;
      active_interval  <= SEC_RESET;
      pending_interval <= SEC_RESET;
      pending_vld      <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      tick_1s   <= 1'b0;
      case (state)
        ST_IDLE: begin
          prescale    <= PRE_ZERO;
          sec_count   <= SEC_ZERO;
          pending_vld <= 1'b0;
          if (interval_load) begin
            active_interval  <= load_val;
            pending_interval <= load_val;
          end
          if (enable) begin
            state <= ST_RUN;
          end
        end

        default: begin
          if (!enable) begin
            // Leaving RUN abandons the current interval, so there is nothing
            // to protect: a same-edge load wins, else a pending value lands.
            state       <= ST_IDLE;
            prescale    <= PRE_ZERO;
            sec_count   <= SEC_ZERO;
            pending_vld <= 1'b0;
            if (interval_load) begin
              active_interval <= load_val;
            end else if (pending_vld) begin
              active_interval <= pending_interval;
            end
          end else begin
            // Loads during RUN are parked until the interval completes;
            // a later load simply overwrites the parked value.
            if (interval_load) begin
              pending_interval <= load_val;
              pending_vld      <= 1'b1;
            end
            if (pre_wrap) begin
              prescale <= PRE_ZERO;
              tick_1s  <= 1'b1;
              if (sec_last) begin
                sec_count <= SEC_ZERO;
                pulse_out <= 1'b1;
                // Interval boundary: apply the newest requested value.
                if (interval_load) begin
                  active_interval <= load_val;
                  pending_vld     <= 1'b0;
                end else if (pending_vld) begin
                  active_interval <= pending_interval;
                  pending_vld     <= 1'b0;
                end
              end else begin
                sec_count <= sec_count + SEC_ONE;
              end
            end else begin
              prescale <= prescale + PRE_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_interval_gen.sv
module tb_pulse_interval_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       interval_load = 1'b0;
  logic [7:0] interval_secs = 8'd0;
  logic       pulse_out;
  logic       tick_1s;
  logic [7:0] sec_count;
  logic       running;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;          // index of the most recent rising edge

  int tick_q[$];        // expected edge numbers after which tick_1s is high
  int pulse_q[$];       // expected edge numbers after which pulse_out is high

  pulse_interval_gen #(.DIV(4), .SEC_W(8), .DEFAULT_SECS(5)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .interval_load(interval_load),
    .interval_secs(interval_secs),
    .pulse_out(pulse_out),
    .tick_1s(tick_1s),
    .sec_count(sec_count),
    .running(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 200000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @edge %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (tick_1s) begin
      if (tick_q.size() == 0) check("unexpected_tick", cyc, -1);
      else check("tick_edge", cyc, tick_q.pop_front());
    end
    if (pulse_out) begin
      if (pulse_q.size() == 0) check("unexpected_pulse", cyc, -1);
      else check("pulse_edge", cyc, pulse_q.pop_front());
      check("pulse_with_tick", int'(tick_1s), 1);
    end
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic start(output int e0);
    enable = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
  endtask

  task automatic stop_at(input int e);
    wait_edge(e - 1);
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_at(input int e, input logic [7:0] v);
    wait_edge(e - 1);
    interval_load = 1'b1;
    interval_secs = v;
    @(negedge clk);
    interval_load = 1'b0;
  endtask

  task automatic push_ticks(input int e0, input int stop_edge);
    for (int t = e0 + 4; t < stop_edge; t += 4) tick_q.push_back(t);
  endtask

  int e0;
  int e1;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(pulse_out), 0);
    check("rst_tick", int'(tick_1s), 0);
    check("rst_sec", int'(sec_count), 0);
    check("rst_running", int'(running), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1) defaults: interval 5, ticks every 4, pulses at +20 and +40
    start(e0);
    push_ticks(e0, e0 + 42);
    pulse_q.push_back(e0 + 20);
    pulse_q.push_back(e0 + 40);
    check("run_after_e0", int'(running), 1);
    wait_edge(e0 + 8);  check("sec_at_8", int'(sec_count), 2);
    wait_edge(e0 + 16); check("sec_at_16", int'(sec_count), 4);
    wait_edge(e0 + 20); check("sec_at_20", int'(sec_count), 0);
    stop_at(e0 + 42);
    check("idle_running", int'(running), 0);

    // 2) idle load of 2 takes effect immediately
    load_at(cyc + 1, 8'd2);
    start(e0);
    push_ticks(e0, e0 + 18);
    pulse_q.push_back(e0 + 8);
    pulse_q.push_back(e0 + 16);
    stop_at(e0 + 18);

    // 3) run-time load of 3 waits for the current 5 s interval to finish
    load_at(cyc + 1, 8'd5);
    start(e0);
    push_ticks(e0, e0 + 46);
    pulse_q.push_back(e0 + 20);
    pulse_q.push_back(e0 + 32);
    pulse_q.push_back(e0 + 44);
    load_at(e0 + 6, 8'd3);
    stop_at(e0 + 46);

    // 4) load of 0 behaves as 1: every tick is a pulse
    load_at(cyc + 1, 8'd0);
    start(e0);
    push_ticks(e0, e0 + 14);
    pulse_q.push_back(e0 + 4);
    pulse_q.push_back(e0 + 8);
    pulse_q.push_back(e0 + 12);
    wait_edge(e0 + 9);  check("sec_int1", int'(sec_count), 0);
    stop_at(e0 + 14);

    // 5) enable drops on the would-be pulse edge: no tick, no pulse
    load_at(cyc + 1, 8'd5);
    start(e0);
    push_ticks(e0, e0 + 20);
    wait_edge(e0 + 19); check("sec_before_drop", int'(sec_count), 4);
    stop_at(e0 + 20);
    check("drop_running", int'(running), 0);
    check("drop_sec", int'(sec_count), 0);
    start(e1);
    push_ticks(e1, e1 + 22);
    pulse_q.push_back(e1 + 20);
    stop_at(e1 + 22);

    // 6) async reset with a pending load of 7: pending value is discarded
    start(e0);
    push_ticks(e0, e0 + 13);
    load_at(e0 + 6, 8'd7);
    wait_edge(e0 + 12);
    @(posedge clk);      // edge e0+13
    #1 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_running", int'(running), 0);
    check("arst_sec", int'(sec_count), 0);
    check("arst_pulse", int'(pulse_out), 0);
    check("arst_tick", int'(tick_1s), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start(e0);
    push_ticks(e0, e0 + 30);
    pulse_q.push_back(e0 + 20);   // interval 7 would pulse at +28 instead
    stop_at(e0 + 30);

    repeat (4) @(negedge clk);
    check("ticks_left", tick_q.size(), 0);
    check("pulses_left", pulse_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
